// File: rtl/group_ser_pkg.sv
// -----------------------------------------------------------------------------
// group_ser_pkg
// Shared definitions for the group serializer:
//   - state_t       : serializer FSM states (IDLE, SHIFT)
//   - DEF_GROUPSIZE : default number of symbols per group
//   - DEF_SYMW      : default symbol width in bits
// -----------------------------------------------------------------------------
package group_ser_pkg;

    localparam int DEF_GROUPSIZE = 8;
    localparam int DEF_SYMW      = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/group_ser_buf.sv
// -----------------------------------------------------------------------------
// group_ser_buf
// One-entry holding buffer for a complete group waiting behind the active one.
// Ports:
//   clk, reset  : clock, asynchronous active-low reset (buffer empties)
//   i_load      : write i_data into the buffer, marks it full
//   i_take      : the buffered group is consumed this cycle, marks it empty
//   i_data      : group to store
//   o_data      : stored group
//   o_full      : buffer holds a group
// A take and a load in the same cycle leave the buffer full with the new
// group: load wins because the old contents are read out combinationally.
// -----------------------------------------------------------------------------
module group_ser_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_take,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_full
);

    logic [W-1:0] r_data;
    logic         r_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else begin
            if (i_load) begin
                r_data <= i_data;
                r_full <= 1'b1;
            end else if (i_take) begin
                r_full <= 1'b0;
            end
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/group_serializer.sv
// -----------------------------------------------------------------------------
// group_serializer
// Accepts a parallel group of GROUPSIZE symbols and emits it one symbol per
// handshake, symbol 0 (LSBs) first. One further group can wait in a holding
// buffer so back-to-back groups stream without bubbles.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   in_data      : parallel group (GROUPSIZE*SYMW bits)
//   in_valid     : in_data valid
//   in_ready     : a group can be accepted this cycle (= buffer not full)
//   out_sym      : current symbol
//   out_valid    : out_sym valid
//   out_ready    : downstream consumes out_sym this cycle
//   out_first    : out_sym is symbol 0 of its group
//   out_last     : out_sym is symbol GROUPSIZE-1 of its group
//   busy         : a group is shifting or buffered
//   o_dbg_state  : current FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready. The
// producer holds its payload stable while valid is high and ready is low;
// ready never depends combinationally on valid.
// -----------------------------------------------------------------------------
module group_serializer
    import group_ser_pkg::*;
#(
    parameter int GROUPSIZE = DEF_GROUPSIZE,
    parameter int SYMW      = DEF_SYMW
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GROUPSIZE*SYMW-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [SYMW-1:0]           out_sym,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_first,
    output logic                      out_last,
    output logic                      busy,
    output state_t                    o_dbg_state
);

    localparam int GW = GROUPSIZE * SYMW;
    localparam int CW = $clog2(GROUPSIZE);
    localparam logic [CW-1:0] CNT_LAST = CW'(GROUPSIZE - 1);

    state_t          r_state, w_state_nxt;
    logic [GW-1:0]   r_shift, w_shift_nxt;
    logic [CW-1:0]   r_cnt,   w_cnt_nxt;

    logic            w_accept;
    logic            w_hs;
    logic            w_last_hs;
    logic            w_buf_load;
    logic            w_buf_take;
    logic            w_buf_full;
    logic [GW-1:0]   w_buf_data;

    assign in_ready  = !w_buf_full;
    assign w_accept  = in_valid && in_ready;
    assign w_hs      = (r_state == SHIFT) && out_ready;
    assign w_last_hs = w_hs && (r_cnt == CNT_LAST);

    // The buffer hands its group to the shift register on the last-symbol
    // handshake. An incoming group goes to the buffer whenever a group is
    // active, except when the active group finishes with the buffer empty:
    // then it loads the shift register directly.
    assign w_buf_take = w_last_hs && w_buf_full;
    assign w_buf_load = w_accept && (r_state == SHIFT) && !(w_last_hs && !w_buf_full);

    group_ser_buf #(
        .W (GW)
    ) u_buf (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_buf_load),
        .i_take (w_buf_take),
        .i_data (in_data),
        .o_data (w_buf_data),
        .o_full (w_buf_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_nxt = in_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last_hs) begin
                    w_cnt_nxt = '0;
                    if (w_buf_full) begin
                        w_shift_nxt = w_buf_data;
                    end else if (w_accept) begin
                        w_shift_nxt = in_data;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_hs) begin
                    w_shift_nxt = r_shift >> SYMW;
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are gated by out_valid so a stale shift register never leaks
    // out while idle.
    assign out_valid   = (r_state == SHIFT);
    assign out_sym     = out_valid ? r_shift[SYMW-1:0] : '0;
    assign out_first   = out_valid && (r_cnt == '0);
    assign out_last    = out_valid && (r_cnt == CNT_LAST);
    assign busy        = (r_state == SHIFT) || w_buf_full;
    assign o_dbg_state = r_state;

endmodule
